mux_nx1_serial: RTL and testbench

Parametrised N-lane to 1-lane serialising multiplexer for the PCIe PHY byte-striping path. It is the single-clock successor of the fixed 4:1 byte mux with valid. One group of LANES words, each with its own valid bit, is captured on a load strobe. The words are then emitted one per clock, lowest lane first, with a per-beat valid, a lane index and a last-beat marker. An optional mode compacts the stream by skipping invalid lanes. A ready/load handshake allows back-to-back groups with no idle cycles.

---
 rtl/mux_nx1_serial.sv | 168 ++++++++++++++++
 tb/tb_mux_nx1_serial.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_serial.sv
// ============================================================================
// mux_nx1_serial : N-lane to 1-lane serialising mux, lowest lane first
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_nx1_serial #(
  parameter int WIDTH        = 8,
  parameter int LANES        = 4,
  parameter int SKIP_INVALID = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LANES*WIDTH-1:0]     in_data,
  input  logic [LANES-1:0]           in_valid,
  input  logic                       in_load,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic [$clog2(LANES)-1:0]   out_lane,
  output logic                       out_last,
  output logic                       err_overflow
);

  localparam int LW = $clog2(LANES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] bank_q [LANES];
  logic [LANES-1:0] vld_q;

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [LW-1:0]    out_lane_q;
  logic             out_last_q;
  logic             err_q;

  logic [WIDTH-1:0] w_lane_data [LANES];
  logic [LW-1:0]    w_first_lane;
  logic [LW-1:0]    w_next_lane;
  logic [LW-1:0]    w_last_lane;
  logic             w_is_final;
  logic             w_load_acc;
  logic             w_grp_empty;

  for (genvar i = 0; i < LANES; i++) begin : g_unpack
    assign w_lane_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Beat-set navigation: pass mode walks every lane, skip mode walks set valid bits.
  if (SKIP_INVALID != 0) begin : g_skip
    always_comb begin
      w_first_lane = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
        if (in_valid[i]) w_first_lane = LW'(i);
      end
    end

    always_comb begin
      w_next_lane = ptr_q;
      for (int i = LANES - 1; i >= 0; i--) begin
        if (vld_q[i] && (LW'(i) > ptr_q)) w_next_lane = LW'(i);
      end
    end

    always_comb begin
      w_last_lane = '0;
      for (int i = 0; i < LANES; i++) begin
        if (vld_q[i]) w_last_lane = LW'(i);
      end
    end

    assign w_grp_empty = (in_valid == '0);
  end else begin : g_pass
    assign w_first_lane = '0;
    assign w_next_lane  = ptr_q + LW'(1);
    assign w_last_lane  = LW'(LANES - 1);
    assign w_grp_empty  = 1'b0;
  end

  assign w_is_final = (ptr_q == w_last_lane);
  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_SEND) && w_is_final);
  assign w_load_acc = in_load && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (w_load_acc && !w_grp_empty) begin
          state_d = S_SEND;
          ptr_d   = w_first_lane;
        end
      end
      S_SEND: begin
        if (!w_is_final) begin
          ptr_d = w_next_lane;
        end else if (w_load_acc && !w_grp_empty) begin
          ptr_d = w_first_lane;
        end else begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the current pointer, so they trail the state by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      vld_q       <= '0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_lane_q  <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;

      if (w_load_acc) begin
        vld_q <= in_valid;
        for (int i = 0; i < LANES; i++) begin
          bank_q[i] <= w_lane_data[i];
        end
      end

      if (in_load && !in_ready) begin
        err_q <= 1'b1;
      end

      if (state_q == S_SEND) begin
        out_valid_q <= vld_q[ptr_q];
        out_data_q  <= vld_q[ptr_q] ? bank_q[ptr_q] : '0;
        out_lane_q  <= ptr_q;
        out_last_q  <= w_is_final;
      end else begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_lane_q  <= '0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_lane     = out_lane_q;
  assign out_last     = out_last_q;
  assign err_overflow = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_nx1_serial.sv
// ============================================================================
// tb_mux_nx1_serial : pass-mode and skip-mode instances against a beat-queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux_nx1_serial;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int LW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [L*W-1:0] p_data, s_data;
  logic [L-1:0]   p_valid, s_valid;
  logic           p_load, s_load;
  logic           p_ready, s_ready;
  logic [W-1:0]   p_odata, s_odata;
  logic           p_ovalid, s_ovalid;
  logic [LW-1:0]  p_olane, s_olane;
  logic           p_olast, s_olast;
  logic           p_err, s_err;

  mux_nx1_serial #(.WIDTH(W), .LANES(L), .SKIP_INVALID(0)) u_pass (
    .clk(clk), .reset(rst), .in_data(p_data), .in_valid(p_valid), .in_load(p_load),
    .in_ready(p_ready), .out_data(p_odata), .out_valid(p_ovalid), .out_lane(p_olane),
    .out_last(p_olast), .err_overflow(p_err)
  );

  mux_nx1_serial #(.WIDTH(W), .LANES(L), .SKIP_INVALID(1)) u_skip (
    .clk(clk), .reset(rst), .in_data(s_data), .in_valid(s_valid), .in_load(s_load),
    .in_ready(s_ready), .out_data(s_odata), .out_valid(s_ovalid), .out_lane(s_olane),
    .out_last(s_olast), .err_overflow(s_err)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic          valid;
    logic [LW-1:0] lane;
    logic          last;
  } beat_t;

  // Beats still owed by each DUT; head is the next beat to appear on the outputs.
  beat_t qp[$];
  beat_t qs[$];
  logic  errp, errs;
  int    checks, errors;

  function automatic beat_t idle_beat();
    beat_t b;
    b = '0;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_group(input bit skip, input logic [L*W-1:0] d, input logic [L-1:0] v);
    int    lanes[$];
    beat_t b;
    for (int i = 0; i < L; i++) begin
      if (!skip || v[i]) lanes.push_back(i);
    end
    foreach (lanes[k]) begin
      b.lane  = LW'(lanes[k]);
      b.valid = v[lanes[k]];
      b.data  = b.valid ? d[lanes[k]*W +: W] : '0;
      b.last  = (k == lanes.size() - 1);
      if (skip) qs.push_back(b);
      else      qp.push_back(b);
    end
  endtask

  task automatic tick();
    beat_t ep, es;
    bit    rp, rs;
    #1;
    rp = (qp.size() <= 1);
    rs = (qs.size() <= 1);
    chk("p_ready", p_ready, rp);
    chk("s_ready", s_ready, rs);
    if (rst) begin
      qp.delete();
      qs.delete();
      errp = 1'b0;
      errs = 1'b0;
      ep   = idle_beat();
      es   = idle_beat();
    end else begin
      ep = idle_beat();
      es = idle_beat();
      if (qp.size() > 0) ep = qp.pop_front();
      if (qs.size() > 0) es = qs.pop_front();
      if (p_load) begin
        if (rp) push_group(1'b0, p_data, p_valid);
        else    errp = 1'b1;
      end
      if (s_load) begin
        if (rs) push_group(1'b1, s_data, s_valid);
        else    errs = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("p_data",  p_odata,  ep.data);
    chk("p_valid", p_ovalid, ep.valid);
    chk("p_lane",  p_olane,  ep.lane);
    chk("p_last",  p_olast,  ep.last);
    chk("p_err",   p_err,    errp);
    chk("s_data",  s_odata,  es.data);
    chk("s_valid", s_ovalid, es.valid);
    chk("s_lane",  s_olane,  es.lane);
    chk("s_last",  s_olast,  es.last);
    chk("s_err",   s_err,    errs);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    errp    = 1'b0;
    errs    = 1'b0;
    rst     = 1'b1;
    p_load  = 1'b0;
    s_load  = 1'b0;
    p_data  = '0;
    s_data  = '0;
    p_valid = '0;
    s_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p_ready", p_ready, 1);
    chk("rst_p_valid", p_ovalid, 0);
    chk("rst_p_data",  p_odata, 0);
    chk("rst_p_lane",  p_olane, 0);
    chk("rst_p_last",  p_olast, 0);
    chk("rst_p_err",   p_err, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_s_valid", s_ovalid, 0);
    rst = 1'b0;

    // Pass mode, all lanes valid
    p_data = 32'h4433_2211; p_valid = 4'b1111; p_load = 1'b1;
    tick();
    p_load = 1'b0;
    repeat (5) tick();

    // Pass mode, sparse valid keeps lane slots
    p_valid = 4'b1010; p_load = 1'b1;
    tick();
    p_load = 1'b0;
    repeat (5) tick();

    // Skip mode, sparse valid compacts
    s_data = 32'h4433_2211; s_valid = 4'b1010; s_load = 1'b1;
    tick();
    s_load = 1'b0;
    repeat (3) tick();

    // Skip mode, empty group
    s_valid = 4'b0000; s_load = 1'b1;
    tick();
    s_load = 1'b0;
    repeat (2) tick();

    // Skip mode, single valid lane
    s_valid = 4'b0100; s_load = 1'b1;
    tick();
    s_load = 1'b0;
    repeat (2) tick();

    // Back-to-back pass groups
    p_data = 32'hA4A3_A2A1; p_valid = 4'b1111; p_load = 1'b1;
    tick();
    p_load = 1'b0;
    for (int n = 0; n < 8 && qp.size() > 1; n++) tick();
    p_data = 32'hB4B3_B2B1; p_load = 1'b1;
    tick();
    p_load = 1'b0;
    repeat (5) tick();

    // Overflow: load while a group is mid-flight
    p_data = 32'hC4C3_C2C1; p_load = 1'b1;
    tick();
    p_load = 1'b0;
    tick();
    p_data = 32'hDEAD_BEEF; p_load = 1'b1;
    tick();
    p_load = 1'b0;
    repeat (5) tick();

    // Reset mid-group, then restart
    p_data = 32'h1234_5678; p_load = 1'b1;
    tick();
    p_load = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p_load = 1'b1;
    tick();
    p_load = 1'b0;
    repeat (5) tick();

    // Reset wins over a simultaneous load
    rst = 1'b1; p_load = 1'b1; s_load = 1'b1; s_valid = 4'b1111;
    tick();
    rst = 1'b0; p_load = 1'b0; s_load = 1'b0;
    repeat (2) tick();

    // Random, load only when model says ready: sustained throughput, no overflow
    for (int n = 0; n < 200; n++) begin
      p_data  = $urandom;
      s_data  = $urandom;
      p_valid = L'($urandom);
      s_valid = L'($urandom);
      p_load  = (qp.size() <= 1) && ($urandom_range(0, 9) < 8);
      s_load  = (qs.size() <= 1) && ($urandom_range(0, 9) < 8);
      tick();
    end
    p_load = 1'b0; s_load = 1'b0;
    repeat (6) tick();

    // Random, unconstrained loads and occasional reset
    for (int n = 0; n < 300; n++) begin
      p_data  = $urandom;
      s_data  = $urandom;
      p_valid = L'($urandom);
      s_valid = L'($urandom);
      p_load  = ($urandom_range(0, 3) == 0);
      s_load  = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0; p_load = 1'b0; s_load = 1'b0;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
